spi_frame_seq: RTL and testbench
================================

Name: spi_frame_seq

Overview:
- Parametrised SPI frame sequencer. It replaces the fixed-sequence LED controller with a generic engine.
- It sends a frame of 1..MAX_BYTES bytes to the byte-level SPI master. Frame bytes are fetched from an external source by index.
- It owns chip-select timing (startup delay, CS setup/hold), the SPI enable divider, and the start/busy handshake.
- It adds request-driven and auto-repeat operation, busy timeout detection, and a done/ack pulse. It sits between the robot command logic (LED/motor messages) and the SPI master.

Parameters:
- CLK_DIV, 12, system clocks per ena_2clk pulse (12 MHz / 12 = 1 MHz, SCK 500 kHz); must be >= 2.
- STARTUP_CYCLES, 500, clocks after reset before any frame may start (synthesis: 2**29-1).
- CS_SETUP_CYCLES, 64, clocks SSBar is held low before the first start.
- CS_HOLD_CYCLES, 16, clocks SSBar stays low after the last byte completes.
- MAX_BYTES, 8, maximum frame length.
- IDX_W, 3, width of byte_idx; IDX_W = clog2(MAX_BYTES).
- BUSY_TIMEOUT, 1023, clocks allowed for busy_spi to rise after start.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req  in  1  frame request; sampled in IDLE.
- repeat_en  in  1  when 1, a new frame starts automatically after DONE with no req needed.
- frame_len  in  IDX_W+1  number of bytes in the frame; latched on frame start.
- byte_data  in  8  byte addressed by byte_idx; sampled in LOAD.
- busy_spi  in  1  SPI master busy.
- byte_idx  out  IDX_W  index of the byte being fetched or sent.
- data_spi  out  8  byte presented to the SPI master.
- start  out  1  one-cycle start pulse to the SPI master.
- ena_2clk  out  1  one-cycle enable every CLK_DIV clocks.
- SSBar  out  1  slave select, active low.
- ack  out  1  one-cycle pulse at frame end.
- error  out  1  sticky flag: busy timeout occurred; cleared by rst or on the next frame start.
- ready  out  1  high in IDLE after startup.

Behaviour:
- All outputs and state are registered except ena_2clk, which is decoded from the divider counter.
- Reset values: SSBar=1; start=ack=error=ready=0; data_spi=8'h00; byte_idx=0; state=STARTUP; internal busy_rg=1; all counters=0.
- Divider: counts 0..CLK_DIV-1. ena_2clk=1 when count==CLK_DIV-1. The count restarts at 0 on wrap or in the cycle after start=1.
- busy_rg: set to 1 in any cycle busy_spi=1. Cleared only when busy_spi=0 and ena_2clk=1. "SPI ready" means busy_rg==0.
- STARTUP: count STARTUP_CYCLES, then go to IDLE.
- IDLE: ready=1. Exit when req=1, or when repeat_en=1 and the previous state was DONE.
  - On exit, latch len = min(frame_len, MAX_BYTES) and clear error.
  - If len==0: go to DONE directly; SSBar stays 1.
  - Otherwise: SSBar<=0 and go to CS_SETUP.
- CS_SETUP: wait CS_SETUP_CYCLES clocks, then go to LOAD with byte_idx=0.
- LOAD (1 clock): data_spi<=byte_data, then go to SEND.
- SEND: wait for SPI ready. In the ready cycle, start<=1 for exactly one clock, then go to WAIT_BUSY.
- WAIT_BUSY: wait for busy_rg=1.
  - If it has not risen after BUSY_TIMEOUT clocks: error<=1, abort to CS_HOLD.
  - On busy_rg=1: if byte_idx==len-1, go to WAIT_LAST; else byte_idx+1 and go to LOAD.
- WAIT_LAST: wait for SPI ready, i.e. the last byte has fully shifted out. Then go to CS_HOLD.
- CS_HOLD: SSBar held 0 for CS_HOLD_CYCLES, then SSBar<=1 and go to DONE.
- DONE (1 clock): ack=1, byte_idx<=0, go to IDLE. In IDLE, repeat_en restarts a frame on the first IDLE cycle.
- Latency: req high in IDLE → SSBar low on the next clock → first start no earlier than 1+CS_SETUP_CYCLES+1 clocks after req.
- Edge cases:
  - req while not IDLE: ignored (not queued).
  - frame_len changes mid-frame: no effect.
  - start is never asserted while busy_rg=1.
  - At most one start per byte.
  - rst mid-frame: synchronous return to reset values; SSBar=1 the next clock.
  - frame_len > MAX_BYTES: clamped.

Test Plan:
- Reset, STARTUP_CYCLES=500, req at cycle 600, frame_len=6, bytes {08,06,04,10,1F,1A}, SPI model busy for 16 ena_2clk → six start pulses, data_spi in that order, SSBar low from cycle 601 until CS_HOLD end, ack once, error=0.
- req held high during STARTUP (first 500 cycles) → no SSBar/start before cycle 500; frame starts on the first IDLE cycle.
- frame_len=0, req → ack one clock later, SSBar never low, no start.
- frame_len=12 with MAX_BYTES=8 → exactly 8 starts, byte_idx 0..7.
- SPI model never raises busy → error=1 after 1023 clocks, SSBar returns high after CS_HOLD, ack pulses; next req clears error.
- repeat_en=1, frame_len=2 → back-to-back frames, each with SSBar deasserted for at least 1 clock between them; rst asserted mid-byte → SSBar=1 and start=0 on the next clock.

Source files
------------

// File: rtl/spi_frame_seq.sv
// spi_frame_seq: frame-level sequencer in front of a byte-wide SPI master.
// Owns chip-select timing, the SPI enable divider and the start/busy handshake.
module spi_frame_seq #(
    parameter int CLK_DIV         = 12,
    parameter int STARTUP_CYCLES  = 500,
    parameter int CS_SETUP_CYCLES = 64,
    parameter int CS_HOLD_CYCLES  = 16,
    parameter int MAX_BYTES       = 8,
    parameter int IDX_W           = 3,
    parameter int BUSY_TIMEOUT    = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             repeat_en,
    input  logic [IDX_W:0]   frame_len,
    input  logic [7:0]       byte_data,
    input  logic             busy_spi,
    output logic [IDX_W-1:0] byte_idx,
    output logic [7:0]       data_spi,
    output logic             start,
    output logic             ena_2clk,
    output logic             SSBar,
    output logic             ack,
    output logic             error,
    output logic             ready,
    output logic [3:0]       fsm_state
);

    typedef enum logic [3:0] {
        ST_STARTUP   = 4'd0,
        ST_IDLE      = 4'd1,
        ST_CS_SETUP  = 4'd2,
        ST_LOAD      = 4'd3,
        ST_SEND      = 4'd4,
        ST_WAIT_BUSY = 4'd5,
        ST_WAIT_LAST = 4'd6,
        ST_CS_HOLD   = 4'd7,
        ST_DONE      = 4'd8
    } state_t;

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(CLK_DIV - 1);
    localparam logic [31:0]      STARTUP_LAST = 32'(STARTUP_CYCLES - 1);
    localparam logic [31:0]      SETUP_LAST   = 32'(CS_SETUP_CYCLES - 1);
    localparam logic [31:0]      HOLD_LAST    = 32'(CS_HOLD_CYCLES - 1);
    localparam logic [31:0]      TIMEOUT_LAST = 32'(BUSY_TIMEOUT - 1);
    localparam logic [IDX_W:0]   MAX_LEN      = (IDX_W + 1)'(MAX_BYTES);

    state_t           state, state_n;
    logic [31:0]      tmr, tmr_n;
    logic [DIV_W-1:0] div_cnt;
    logic             busy_rg;
    logic             from_done;
    logic [IDX_W:0]   len, len_n;
    logic [IDX_W:0]   len_clamped;
    logic [IDX_W-1:0] idx_n;
    logic [7:0]       data_n;
    logic             start_n, ssbar_n, ack_n, error_n, ready_n;
    logic             spi_ready;
    logic             last_byte;

    assign fsm_state   = state;
    assign ena_2clk    = (div_cnt == DIV_LAST);
    assign spi_ready   = !busy_rg;
    assign len_clamped = (frame_len > MAX_LEN) ? MAX_LEN : frame_len;
    assign last_byte   = ({1'b0, byte_idx} == (len - 1'b1));

    // The divider is re-phased after every start so the master's first shift
    // happens a full CLK_DIV period later.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (start || ena_2clk) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // busy_rg only falls on an enable tick, so a master that drops busy
    // between ticks is not treated as ready until it could take a new start.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_rg <= 1'b1;
        end else if (busy_spi) begin
            busy_rg <= 1'b1;
        end else if (ena_2clk) begin
            busy_rg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_STARTUP;
            tmr       <= '0;
            len       <= '0;
            byte_idx  <= '0;
            data_spi  <= 8'h00;
            start     <= 1'b0;
            SSBar     <= 1'b1;
            ack       <= 1'b0;
            error     <= 1'b0;
            ready     <= 1'b0;
            from_done <= 1'b0;
        end else begin
            state     <= state_n;
            tmr       <= tmr_n;
            len       <= len_n;
            byte_idx  <= idx_n;
            data_spi  <= data_n;
            start     <= start_n;
            SSBar     <= ssbar_n;
            ack       <= ack_n;
            error     <= error_n;
            ready     <= ready_n;
            from_done <= (state == ST_DONE);
        end
    end

    // Handshake: start is a one-clock pulse issued only when busy_rg and
    // busy_spi are both low; the byte is accepted once busy_rg rises, and it
    // has finished shifting once busy_rg has fallen again.
    always_comb begin
        state_n = state;
        tmr_n   = tmr;
        len_n   = len;
        idx_n   = byte_idx;
        data_n  = data_spi;
        start_n = 1'b0;
        ssbar_n = SSBar;
        error_n = error;
        unique case (state)
            ST_STARTUP: begin
                if (tmr == STARTUP_LAST) begin
                    tmr_n   = '0;
                    state_n = ST_IDLE;
                end else begin
                    tmr_n = tmr + 32'd1;
                end
            end
            ST_IDLE: begin
                if (req || (repeat_en && from_done)) begin
                    len_n   = len_clamped;
                    error_n = 1'b0;
                    tmr_n   = '0;
                    if (len_clamped == '0) begin
                        state_n = ST_DONE;
                    end else begin
                        ssbar_n = 1'b0;
                        state_n = ST_CS_SETUP;
                    end
                end
            end
            ST_CS_SETUP: begin
                if (tmr == SETUP_LAST) begin
                    tmr_n   = '0;
                    idx_n   = '0;
                    state_n = ST_LOAD;
                end else begin
                    tmr_n = tmr + 32'd1;
                end
            end
            ST_LOAD: begin
                data_n  = byte_data;
                state_n = ST_SEND;
            end
            ST_SEND: begin
                if (spi_ready && !busy_spi) begin
                    start_n = 1'b1;
                    tmr_n   = '0;
                    state_n = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (busy_rg) begin
                    tmr_n = '0;
                    if (last_byte) begin
                        state_n = ST_WAIT_LAST;
                    end else begin
                        idx_n   = byte_idx + 1'b1;
                        state_n = ST_LOAD;
                    end
                end else if (tmr == TIMEOUT_LAST) begin
                    error_n = 1'b1;
                    tmr_n   = '0;
                    state_n = ST_CS_HOLD;
                end else begin
                    tmr_n = tmr + 32'd1;
                end
            end
            ST_WAIT_LAST: begin
                if (spi_ready) begin
                    tmr_n   = '0;
                    state_n = ST_CS_HOLD;
                end
            end
            ST_CS_HOLD: begin
                if (tmr == HOLD_LAST) begin
                    tmr_n   = '0;
                    ssbar_n = 1'b1;
                    state_n = ST_DONE;
                end else begin
                    tmr_n = tmr + 32'd1;
                end
            end
            ST_DONE: begin
                idx_n   = '0;
                state_n = ST_IDLE;
            end
            default: begin
                tmr_n   = '0;
                ssbar_n = 1'b1;
                state_n = ST_STARTUP;
            end
        endcase
        ack_n   = (state_n == ST_DONE);
        ready_n = (state_n == ST_IDLE);
    end

endmodule

// File: tb/tb_spi_frame_seq.sv
// Randomized bench for spi_frame_seq: a busy-counting SPI master model plus a
// frame-level reference (expected byte queue, start count, CS/timeout timing).
module tb_spi_frame_seq;

    localparam int CLK_DIV         = 12;
    localparam int STARTUP_CYCLES  = 500;
    localparam int CS_SETUP_CYCLES = 64;
    localparam int CS_HOLD_CYCLES  = 16;
    localparam int MAX_BYTES       = 8;
    localparam int IDX_W           = 3;
    localparam int BUSY_TIMEOUT    = 1023;

    logic             clk = 1'b0;
    logic             rst;
    logic             req;
    logic             repeat_en;
    logic [IDX_W:0]   frame_len;
    logic [7:0]       byte_data;
    logic             busy_spi;
    logic [IDX_W-1:0] byte_idx;
    logic [7:0]       data_spi;
    logic             start;
    logic             ena_2clk;
    logic             SSBar;
    logic             ack;
    logic             error;
    logic             ready;
    logic [3:0]       fsm_state;

    logic [7:0] mem [MAX_BYTES];
    logic [7:0] exp_q [$];
    int         checks   = 0;
    int         failures = 0;

    bit   spi_dead = 1'b0;
    int   spi_len  = 16;
    int   spi_cnt  = 0;
    logic spi_busy = 1'b0;

    spi_frame_seq #(
        .CLK_DIV(CLK_DIV), .STARTUP_CYCLES(STARTUP_CYCLES),
        .CS_SETUP_CYCLES(CS_SETUP_CYCLES), .CS_HOLD_CYCLES(CS_HOLD_CYCLES),
        .MAX_BYTES(MAX_BYTES), .IDX_W(IDX_W), .BUSY_TIMEOUT(BUSY_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .repeat_en(repeat_en),
        .frame_len(frame_len), .byte_data(byte_data), .busy_spi(busy_spi),
        .byte_idx(byte_idx), .data_spi(data_spi), .start(start),
        .ena_2clk(ena_2clk), .SSBar(SSBar), .ack(ack), .error(error),
        .ready(ready), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    assign byte_data = mem[byte_idx];
    assign busy_spi  = spi_busy;

    // SPI master model: busy for spi_len enable ticks after each accepted start.
    always @(negedge clk) begin
        if (rst) begin
            spi_busy = 1'b0;
            spi_cnt  = 0;
        end else if (!spi_busy) begin
            if (start && !spi_dead) begin
                spi_busy = 1'b1;
                spi_cnt  = spi_len;
            end
        end else if (ena_2clk) begin
            spi_cnt = spi_cnt - 1;
            if (spi_cnt == 0) spi_busy = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic fill_mem();
        for (int i = 0; i < MAX_BYTES; i++) mem[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 1'b0;
        repeat_en = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_frame(input int len, input bit dead, input int fall_lo,
                             input int fall_hi, input bit held);
        int n, cyc, starts, fall, first_start, last_start, last_busy, ack_cyc, err_cyc;
        logic [7:0] got;
        n = (len > MAX_BYTES) ? MAX_BYTES : len;
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(mem[i]);
        spi_dead = dead;
        cyc = 0; starts = 0; fall = -1; first_start = -1; last_start = -1;
        last_busy = -1; ack_cyc = -1; err_cyc = -1;
        if (!held) @(negedge clk);
        req = 1'b1;
        frame_len = (IDX_W + 1)'(len);
        while (ack_cyc < 0 && cyc < 6000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!held && cyc == 40) begin
                req = 1'b1;
                frame_len = (IDX_W + 1)'($urandom_range(0, 15));
            end else if (!held || !SSBar) begin
                req = 1'b0;
            end
            if (held && cyc == 100) check("ready_in_startup", ready, 0);
            if (!held && cyc == 1) check("error_cleared_on_start", error, 0);
            if (!SSBar && fall < 0) fall = cyc;
            if (spi_busy) last_busy = cyc;
            if (error && err_cyc < 0) err_cyc = cyc;
            if (start) begin
                if (first_start < 0) first_start = cyc;
                last_start = cyc;
                check("start_while_busy", spi_busy, 0);
                check("start_cs_low", SSBar, 0);
                check("byte_idx_at_start", byte_idx, starts);
                if (exp_q.size() == 0) begin
                    check("extra_start", starts, n);
                end else begin
                    got = exp_q.pop_front();
                    check("data_spi", data_spi, got);
                end
                starts++;
            end
            if (ack) ack_cyc = cyc;
        end
        check("ack_seen", ack_cyc > 0, 1);
        check("ssbar_high_at_ack", SSBar, 1);
        check("start_count", starts, dead ? ((n > 0) ? 1 : 0) : n);
        check("error_flag", error, dead && (n > 0));
        if (n == 0) begin
            check("len0_ack_latency", ack_cyc, 1);
            check("len0_no_cs", fall, -1);
        end else begin
            check("cs_fall_time", (fall >= fall_lo) && (fall <= fall_hi), 1);
            check("cs_setup_gap", (first_start - fall) >= CS_SETUP_CYCLES + 1, 1);
        end
        if (!dead) begin
            check("exp_q_empty", exp_q.size(), 0);
            if (n > 0) check("cs_hold_time", (ack_cyc - last_busy) >= CS_HOLD_CYCLES, 1);
        end else if (n > 0) begin
            check("timeout_time", (err_cyc - last_start >= BUSY_TIMEOUT) &&
                                  (err_cyc - last_start <= BUSY_TIMEOUT + 2), 1);
            check("timeout_ack_time", (ack_cyc - last_start) >= BUSY_TIMEOUT + CS_HOLD_CYCLES, 1);
        end
        @(posedge clk);
        #1;
        check("ack_single_pulse", ack, 0);
        check("ready_in_idle", ready, 1);
        repeat (3) @(posedge clk);
        #1;
        check("no_queued_req", SSBar, 1);
        spi_dead = 1'b0;
    endtask

    task automatic run_repeat();
        int cyc, acks, starts, ack1, refall;
        logic [7:0] got;
        exp_q.delete();
        for (int f = 0; f < 3; f++) begin
            exp_q.push_back(mem[0]);
            exp_q.push_back(mem[1]);
        end
        spi_dead = 1'b0;
        cyc = 0; acks = 0; starts = 0; ack1 = -1; refall = -1;
        @(negedge clk);
        repeat_en = 1'b1;
        frame_len = (IDX_W + 1)'(2);
        req = 1'b1;
        while (acks < 2 && cyc < 8000) begin
            @(posedge clk);
            #1;
            cyc++;
            req = 1'b0;
            if (start) begin
                check("rep_start_while_busy", spi_busy, 0);
                if (exp_q.size() == 0) begin
                    check("rep_extra_start", starts, 4);
                end else begin
                    got = exp_q.pop_front();
                    check("rep_data_spi", data_spi, got);
                end
                starts++;
            end
            if (acks == 1 && !SSBar && refall < 0) refall = cyc;
            if (ack) begin
                acks++;
                if (acks == 1) ack1 = cyc;
            end
        end
        check("rep_acks", acks, 2);
        check("rep_starts", starts, 4);
        check("rep_cs_gap", (refall - ack1 >= 1) && (refall - ack1 <= 3), 1);
        cyc = 0;
        while (!(spi_busy && !SSBar) && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("rep_third_frame_busy", spi_busy, 1);
        @(negedge clk);
        rst = 1'b1;
        repeat_en = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_ssbar", SSBar, 1);
        check("midreset_start", start, 0);
        check("midreset_ready", ready, 0);
        check("midreset_byte_idx", byte_idx, 0);
    endtask

    initial begin
        rst = 1'b1;
        req = 1'b0;
        repeat_en = 1'b0;
        frame_len = '0;
        fill_mem();
        repeat (3) @(negedge clk);
        check("reset_ssbar", SSBar, 1);
        check("reset_start", start, 0);
        check("reset_ack", ack, 0);
        check("reset_error", error, 0);
        check("reset_ready", ready, 0);
        check("reset_data_spi", data_spi, 0);
        check("reset_byte_idx", byte_idx, 0);

        rst = 1'b0;
        repeat (599) @(negedge clk);
        mem = '{8'h08, 8'h06, 8'h04, 8'h10, 8'h1F, 8'h1A, 8'h00, 8'h00};
        spi_len = 16;
        run_frame(6, 1'b0, 1, 1, 1'b0);

        fill_mem();
        spi_len = $urandom_range(1, 16);
        run_frame(12, 1'b0, 1, 1, 1'b0);

        run_frame(0, 1'b0, 1, 1, 1'b0);

        fill_mem();
        run_frame($urandom_range(1, 8), 1'b1, 1, 1, 1'b0);

        fill_mem();
        spi_len = $urandom_range(1, 16);
        run_frame($urandom_range(1, 8), 1'b0, 1, 1, 1'b0);

        for (int k = 0; k < 5; k++) begin
            fill_mem();
            spi_len = $urandom_range(1, 16);
            run_frame($urandom_range(0, 15), 1'b0, 1, 1, 1'b0);
        end

        fill_mem();
        spi_len = $urandom_range(1, 8);
        run_repeat();

        do_reset();
        fill_mem();
        spi_len = $urandom_range(1, 16);
        run_frame(3, 1'b0, STARTUP_CYCLES + 1, STARTUP_CYCLES + 2, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
